// File: rtl/rob_commit.sv
// Reorder buffer with in-order retirement: allocates at the tail, marks entries done
// on write-back, and retires at most one done entry per cycle from the head.
module rob_commit #(
    parameter int ROB_DEPTH = 8,
    parameter int IDX_W     = 3,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [IDX_W:0]    rob_count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [REG_W-1:0]     rd_q    [ROB_DEPTH];
    logic [DATA_W-1:0]    value_q [ROB_DEPTH];
    logic [IDX_W-1:0]     head_q, head_d;
    logic [IDX_W-1:0]     tail_q, tail_d;
    logic [IDX_W:0]       count_q, count_d;

    logic                 commit_valid_q;
    logic [REG_W-1:0]     commit_rd_q;
    logic [DATA_W-1:0]    commit_value_q;
    logic [IDX_W-1:0]     commit_idx_q;

    logic accept;
    logic do_commit;
    logic wb_take;

    assign alloc_ready  = (count_q != FULL_CNT);
    assign alloc_idx    = tail_q;
    assign rob_count    = count_q;
    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_idx   = commit_idx_q;

    assign accept    = alloc_valid && alloc_ready;
    assign do_commit = busy_q[head_q] && done_q[head_q];
    // Free or already-done targets are dropped; the first result wins.
    assign wb_take   = wb_valid && busy_q[wb_idx] && !done_q[wb_idx];

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (wb_take) begin
            done_d[wb_idx] = 1'b1;
        end
        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        if (accept) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + 1'b1;
        end
        case ({accept, do_commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only read while the entry is busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q[tail_q] <= alloc_rd;
        end
        if (wb_take) begin
            value_q[wb_idx] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_idx_q   <= '0;
        end else begin
            commit_valid_q <= do_commit;
            if (do_commit) begin
                commit_rd_q    <= rd_q[head_q];
                commit_value_q <= value_q[head_q];
                commit_idx_q   <= head_q;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Randomised and directed stimulus for rob_commit, checked against a queue-based
// program-order model of the reorder buffer.
module tb_rob_commit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        wb_valid;
    logic [2:0]  wb_idx;
    logic [31:0] wb_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_idx;
    logic [3:0]  rob_count;

    always #5 clk = ~clk;

    rob_commit #(.ROB_DEPTH(8), .IDX_W(3), .DATA_W(32), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .wb_value     (wb_value),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_value (commit_value),
        .commit_idx   (commit_idx),
        .rob_count    (rob_count)
    );

    typedef struct {
        int          idx;
        int          rd;
        bit          done;
        int unsigned value;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          exp_cv;
    int          exp_rd;
    int unsigned exp_val;
    int          exp_idx;
    int          errors = 0;
    int          checks = 0;
    int          n_commits = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit av, input int ard,
                        input bit wv, input int widx, input int unsigned wval);
        bit acc;
        bit com;
        @(negedge clk);
        reset       = rst;
        alloc_valid = av;
        alloc_rd    = 5'(ard);
        wb_valid    = wv;
        wb_idx      = 3'(widx);
        wb_value    = wval;
        #1;
        if (!rst) begin
            chk("alloc_ready", 64'(alloc_ready), 64'(q.size() != DEPTH));
            chk("alloc_idx", 64'(alloc_idx), 64'(m_tail));
        end
        if (rst) begin
            q.delete();
            m_tail  = 0;
            exp_cv  = 0;
            exp_rd  = 0;
            exp_val = 0;
            exp_idx = 0;
        end else begin
            acc = av && (q.size() != DEPTH);
            com = (q.size() > 0) && q[0].done;
            exp_cv = com;
            if (com) begin
                exp_rd  = q[0].rd;
                exp_val = q[0].value;
                exp_idx = q[0].idx;
                void'(q.pop_front());
            end
            if (wv) begin
                foreach (q[i]) begin
                    if (q[i].idx == widx && !q[i].done) begin
                        q[i].done  = 1'b1;
                        q[i].value = wval;
                    end
                end
            end
            if (acc) begin
                q.push_back('{idx: m_tail, rd: ard & 31, done: 1'b0, value: 0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        chk("commit_valid", 64'(commit_valid), 64'(exp_cv));
        chk("commit_rd", 64'(commit_rd), 64'(exp_rd));
        chk("commit_value", 64'(commit_value), 64'(exp_val));
        chk("commit_idx", 64'(commit_idx), 64'(exp_idx));
        chk("rob_count", 64'(rob_count), 64'(q.size()));
        if (exp_cv) begin
            n_commits++;
            $display("commit rd=%0d value=0x%08h idx=%0d count=%0d", exp_rd, exp_val, exp_idx, q.size());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; alloc_valid = 0; alloc_rd = 0; wb_valid = 0; wb_idx = 0; wb_value = 0;
        m_tail = 0; exp_cv = 0; exp_rd = 0; exp_val = 0; exp_idx = 0;

        // Reset while requests are active
        step(1, 1, 7, 1, 0, 32'h1234);
        step(1, 1, 7, 1, 0, 32'h1234);
        idle(1);

        // Single instruction
        step(0, 1, 5, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0, 32'hAA);
        idle(3);

        // Out-of-order completion
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 2, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 2, 32'h33);
        step(0, 0, 0, 1, 1, 32'h22);
        step(0, 0, 0, 1, 0, 32'h11);
        idle(5);

        // Full, illegal/duplicate write-back, wrap with simultaneous alloc/commit
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4, 32'hDEAD);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 10 + i, 0, 0, 0);
        step(0, 1, 30, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h11);
        step(0, 0, 0, 1, 0, 32'hFF);
        step(0, 1, 31, 1, 1, 32'h55);
        step(0, 1, 29, 0, 0, 0);
        idle(2);

        // Reset mid-flight
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 4, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0);
        step(0, 1, 6, 1, 1, 32'h77);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 8, 0, 0, 0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit rst;
            bit av;
            bit wv;
            int widx;
            rst = ($urandom_range(0, 199) == 0);
            av  = ($urandom_range(0, 9) < 6);
            wv  = ($urandom_range(0, 9) < 7);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                widx = q[$urandom_range(0, q.size() - 1)].idx;
            else
                widx = $urandom_range(0, DEPTH - 1);
            step(rst, av, $urandom_range(0, 31), wv, widx, $urandom);
        end

        // Drain everything still outstanding
        for (int n = 0; n < 40; n++) begin
            if (q.size() > 0) step(0, 0, 0, 1, q[q.size() - 1 - (n % q.size())].idx, $urandom);
            else idle(1);
        end
        chk("drained", 64'(rob_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
